keypad_scan_4x4: RTL

- Input-side counterpart of the team's multiplexed 7-segment display driver.
- The display driver time-multiplexes digit selects outward. This block time-multiplexes column drives outward and reads row returns from a 4x4 hex keypad.
- It debounces the returns and delivers a 4-bit hex key code with a one-cycle strobe.
- It feeds the operand-entry logic ahead of the adder/display path.

---
 rtl/keypad_scan_4x4_pkg.sv | 44 ++++
 rtl/keypad_scan_4x4_if.sv | 16 +
 rtl/keypad_scan_4x4_scan_tick_gen.sv | 28 ++
 rtl/keypad_scan_4x4.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/keypad_scan_4x4_pkg.sv
// Shared types, sizes and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int NCOL  = 4;
  localparam int NROW  = 4;

  // Row returns with no key pulling any row down.
  localparam logic [NROW-1:0] ALL_HIGH = 4'b1111;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  // True when exactly one row return is pulled low.
  function automatic logic one_low(input logic [NROW-1:0] rows);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NROW; i++) begin
      if (!rows[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  // Index of the (single) low row in a one-low pattern.
  function automatic logic [1:0] low_idx(input logic [NROW-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NROW; i++) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Hex code of a key at (row, col).
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row,
                                                input logic [1:0] col);
    return KEY_W'(row) * KEY_W'(NCOL) + KEY_W'(col);
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// Keypad-side and consumer-side signal bundle of the keypad scanner.
interface keypad_scan_4x4_if;
  import keypad_pkg::*;

  logic [NROW-1:0]  ROW;
  logic [NCOL-1:0]  COL;
  logic [KEY_W-1:0] KEY;
  logic             KEY_VALID;
  logic             KEY_HELD;

  // Environment side: keypad drives rows, consumer reads key outputs.
  modport master (output ROW, input COL, KEY, KEY_VALID, KEY_HELD);
  // Scanner side.
  modport slave  (input ROW, output COL, KEY, KEY_VALID, KEY_HELD);

endinterface

// File: rtl/keypad_scan_4x4_scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module scan_tick_gen #(
  parameter int DIV = 1024
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 hex keypad scanner: walks an active-low column drive, debounces the
// row returns and reports each accepted key with a one-cycle strobe.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic             CLK,
  input logic             RST_N,
  keypad_scan_4x4_if.slave kp
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic             w_tick;
  logic [NROW-1:0]  r_sync1, r_sync2;
  kp_state_e        r_state, w_state_nxt;
  logic [1:0]       r_col_idx, w_col_nxt;
  logic [NROW-1:0]  r_pat, w_pat_nxt;
  logic [CNT_W-1:0] r_deb_cnt, w_deb_nxt;
  logic [CNT_W-1:0] r_rel_cnt, w_rel_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic             r_key_valid, w_valid_nxt;
  logic             r_key_held, w_held_nxt;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (w_tick)
  );

  // Two-stage synchronizer for the asynchronous row returns.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= ALL_HIGH;
      r_sync2 <= ALL_HIGH;
    end else begin
      r_sync1 <= kp.ROW;
      r_sync2 <= r_sync1;
    end
  end

  // State, column, counters and key outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= SCAN;
      r_col_idx   <= 2'd0;
      r_pat       <= ALL_HIGH;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_nxt;
      r_pat       <= w_pat_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  // Next-state decisions, taken only on scan ticks; the column stays frozen
  // on the pressed key from first detection until the release is debounced.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_pat_nxt   = r_pat;
    w_deb_nxt   = r_deb_cnt;
    w_rel_nxt   = r_rel_cnt;
    w_key_nxt   = r_key;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (one_low(r_sync2)) begin
            w_pat_nxt = r_sync2;
            if (DEBOUNCE_SCANS == 1) begin
              w_key_nxt   = key_code(low_idx(r_sync2), r_col_idx);
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_deb_nxt   = CNT_W'(1);
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            // Idle or ghosted (several rows low): keep walking the columns.
            w_col_nxt = r_col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (r_sync2 == r_pat) begin
            w_deb_nxt = r_deb_cnt + CNT_W'(1);
            if (w_deb_nxt == CNT_DONE) begin
              w_key_nxt   = key_code(low_idx(r_pat), r_col_idx);
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_state_nxt = HOLD;
            end
          end else begin
            w_deb_nxt   = '0;
            w_col_nxt   = r_col_idx + 2'd1;
            w_state_nxt = SCAN;
          end
        end
        HOLD: begin
          if (r_sync2 == ALL_HIGH) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_held_nxt  = 1'b0;
              w_col_nxt   = r_col_idx + 2'd1;
              w_state_nxt = SCAN;
            end else begin
              w_rel_nxt   = CNT_W'(1);
              w_state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (r_sync2 == ALL_HIGH) begin
            w_rel_nxt = r_rel_cnt + CNT_W'(1);
            if (w_rel_nxt == CNT_DONE) begin
              w_held_nxt  = 1'b0;
              w_col_nxt   = r_col_idx + 2'd1;
              w_state_nxt = SCAN;
            end
          end else begin
            w_rel_nxt   = '0;
            w_state_nxt = HOLD;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  assign kp.COL       = ~(NCOL'(1) << r_col_idx);
  assign kp.KEY       = r_key;
  assign kp.KEY_VALID = r_key_valid;
  assign kp.KEY_HELD  = r_key_held;

endmodule
